cache_lookup_ctrl: RTL and testbench
====================================

# cache_lookup_ctrl

Sequencing controller for one set-associative cache slice in the o-ram path. It accepts one PE lookup at a time and drives the tag array read and the tag-comparator enable (peEN_2). It consumes the comparator's registered HIT/hit_encode. On a miss it selects a victim way, fetches the line from the memory side, and writes the tag and data arrays before responding to the PE.

## Interface
- DOSA, 4: number of ways; power of two, at least 2.
- ENCODER_WIDTH, $clog2(DOSA): width of a way index.
- TAG_W, 16: tag width excluding the valid bit.
- IDX_W, 6: set index width; sets = 2^IDX_W.
- DATA_W, 512: line width.
- clk  in  1  single clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- req_valid  in  1  PE lookup request.
- req_ready  out  1  controller can accept a request.
- req_tag  in  TAG_W  request tag.
- req_idx  in  IDX_W  request set index.
- tag_rd_idx  out  IDX_W  set index presented to the tag/valid array.
- peEN_2  out  1  comparator stage enable.
- HIT  in  1  registered comparator hit, valid the cycle after peEN_2.
- hit_encode  in  ENCODER_WIDTH  registered hit way.
- way_valid  in  DOSA  valid bits of the set, aligned with HIT.
- mem_req_valid  out  1  line fetch request.
- mem_req_ready  in  1  memory accepts the fetch.
- mem_req_addr  out  TAG_W+IDX_W  {tag, idx} of the line.
- mem_rsp_valid  in  1  line data returned.
- mem_rsp_data  in  DATA_W  returned line.
- fill_we  out  1  write strobe for the tag and data arrays.
- fill_way  out  ENCODER_WIDTH  way being written.
- fill_idx  out  IDX_W  set being written.
- fill_tag  out  TAG_W+1  {1'b1, tag}.
- fill_data  out  DATA_W  line being written.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_hit  out  1  1 = hit, 0 = filled miss.
- rsp_way  out  ENCODER_WIDTH  way holding the line.
- busy  out  1  state is not IDLE.
- hit_cnt, miss_cnt  out  32 each  saturating performance counters.

## Operation
- FSM states: IDLE, LOOKUP, COMPARE, MREQ, MWAIT, FILL, RESP.
- IDLE:
  - req_ready=1.
  - When req_valid is high, latch req_tag and req_idx and go to LOOKUP.
- LOOKUP:
  - tag_rd_idx = latched idx. tag_rd_idx holds this value from LOOKUP through RESP.
  - peEN_2=1 for exactly this one cycle. Go to COMPARE.
- COMPARE: sample HIT, hit_encode and way_valid.
  - HIT=1: rsp_way=hit_encode, rsp_hit=1, hit_cnt+1, go to RESP.
  - HIT=0: choose the victim and go to MREQ. miss_cnt+1.
  - Victim is the lowest-index way with way_valid=0.
  - If every way is valid, the victim is rr_ptr[idx], and the victim is marked as "replaced".
- rr_ptr:
  - Array of 2^IDX_W entries, each ENCODER_WIDTH bits; all entries reset to 0.
  - Updated only in FILL when the victim was replaced: rr_ptr[idx] <= rr_ptr[idx]+1, wrapping modulo DOSA.
- MREQ:
  - mem_req_valid=1, mem_req_addr={tag, idx}.
  - Both hold stable until mem_req_ready is seen. Go to MWAIT on that cycle.
- MWAIT:
  - Wait for mem_rsp_valid, then latch mem_rsp_data and go to FILL.
  - mem_rsp_valid in any other state is ignored.
- FILL:
  - fill_we=1 for one cycle, with fill_way=victim, fill_idx=idx, fill_tag={1'b1, tag}, fill_data=latched line.
  - rsp_way=victim, rsp_hit=0. Go to RESP.
- RESP: rsp_valid=1 for one cycle. Go to IDLE.
- Counters saturate at 32'hFFFF_FFFF and never wrap.

## Timing
- Reset values:
  - State is IDLE, so req_ready=1.
  - All other outputs are 0: peEN_2, mem_req_valid, fill_we, rsp_valid, rsp_hit, rsp_way, busy, both counters, mem_req_addr, fill_*, tag_rd_idx.
- Acceptance cycle is T.
  - Hit: peEN_2 at T+1, HIT sampled at T+2, rsp_valid at T+3.
  - Miss with no stalls (mem_req_ready=1 at T+3, mem_rsp_valid=1 at T+4): fill_we at T+5, rsp_valid at T+6.
  - Every cycle of ready or response delay adds one cycle.
- One request is outstanding at a time. req_ready is 0 from T+1 until the cycle after rsp_valid.
- Reset assertion in any state:
  - Returns to IDLE immediately and clears all outputs, counters and rr_ptr.
  - An in-flight mem_req is abandoned. A late mem_rsp_valid is ignored.
- Outputs are registered or decoded from state only. There is no combinational path from inputs to outputs other than mem_req_valid holding.

## Test plan
- Reset: hold RST_N=0 mid-MWAIT, then release -> all outputs 0, req_ready=1, counters 0. A mem_rsp_valid pulse after release produces no fill_we.
- Hit: tag 0x1234, idx 5, HIT=1, hit_encode=2 at T+2 -> peEN_2 only at T+1, rsp_valid at T+3 with rsp_hit=1 and rsp_way=2, hit_cnt=1.
- Cold misses: idx 3, way_valid=4'b0000 then 4'b0001 -> fill_way 0 then 1, fill_tag={1,tag}, rr_ptr[3] unchanged, miss_cnt=2.
- Full-set replacement: idx 7, way_valid=4'b1111, five misses -> fill_way sequence 0,1,2,3,0. rr_ptr for idx 8 stays 0.
- Backpressure: mem_req_ready low for 5 cycles, then response delayed 3 cycles -> mem_req_valid and mem_req_addr stable throughout, rsp_valid at T+14.
- Saturation: preload hit_cnt to 0xFFFF_FFFE, then two hits -> 0xFFFF_FFFF, no wrap.

Source files
------------

// File: rtl/cache_lookup_ctrl.sv
// Lookup/fill sequencer for one set-associative cache slice: issues the tag read
// and comparator enable, and on a miss fetches, installs and reports the line.
module cache_lookup_ctrl #(
  parameter int DOSA          = 4,
  parameter int ENCODER_WIDTH = $clog2(DOSA),
  parameter int TAG_W         = 16,
  parameter int IDX_W         = 6,
  parameter int DATA_W        = 512
) (
  input  logic                     clk,
  input  logic                     RST_N,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [TAG_W-1:0]         req_tag,
  input  logic [IDX_W-1:0]         req_idx,
  output logic [IDX_W-1:0]         tag_rd_idx,
  output logic                     peEN_2,
  input  logic                     HIT,
  input  logic [ENCODER_WIDTH-1:0] hit_encode,
  input  logic [DOSA-1:0]          way_valid,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [TAG_W+IDX_W-1:0]   mem_req_addr,
  input  logic                     mem_rsp_valid,
  input  logic [DATA_W-1:0]        mem_rsp_data,
  output logic                     fill_we,
  output logic [ENCODER_WIDTH-1:0] fill_way,
  output logic [IDX_W-1:0]         fill_idx,
  output logic [TAG_W:0]           fill_tag,
  output logic [DATA_W-1:0]        fill_data,
  output logic                     rsp_valid,
  output logic                     rsp_hit,
  output logic [ENCODER_WIDTH-1:0] rsp_way,
  output logic                     busy,
  output logic [31:0]              hit_cnt,
  output logic [31:0]              miss_cnt
);

  localparam int SETS = 1 << IDX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_COMPARE,
    S_MREQ,
    S_MWAIT,
    S_FILL,
    S_RESP
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;

  logic [TAG_W-1:0]         r_tag;
  logic [IDX_W-1:0]         r_idx;
  logic [ENCODER_WIDTH-1:0] r_victim;
  logic                     r_replaced;
  logic                     r_rsp_hit;
  logic [ENCODER_WIDTH-1:0] r_rsp_way;
  logic [DATA_W-1:0]        r_line;
  logic [31:0]              r_hit_cnt;
  logic [31:0]              r_miss_cnt;
  logic [ENCODER_WIDTH-1:0] r_rr_ptr [SETS];

  logic                     w_free_found;
  logic [ENCODER_WIDTH-1:0] w_free_way;
  logic [ENCODER_WIDTH-1:0] w_rr_cur;
  logic                     w_hit_evt;
  logic                     w_miss_evt;

  // Lowest-index invalid way; scanning downward leaves the smallest match last.
  always_comb begin
    w_free_found = 1'b0;
    w_free_way   = '0;
    for (int i = DOSA - 1; i >= 0; i--) begin
      if (!way_valid[i]) begin
        w_free_found = 1'b1;
        w_free_way   = ENCODER_WIDTH'(i);
      end
    end
  end

  assign w_rr_cur   = r_rr_ptr[r_idx];
  assign w_hit_evt  = (r_state == S_COMPARE) && HIT;
  assign w_miss_evt = (r_state == S_COMPARE) && !HIT;

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    req_ready     = 1'b0;
    peEN_2        = 1'b0;
    mem_req_valid = 1'b0;
    fill_we       = 1'b0;
    rsp_valid     = 1'b0;
    busy          = 1'b1;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          w_state_next = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        peEN_2       = 1'b1;
        w_state_next = S_COMPARE;
      end
      S_COMPARE: begin
        w_state_next = HIT ? S_RESP : S_MREQ;
      end
      S_MREQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          w_state_next = S_MWAIT;
        end
      end
      S_MWAIT: begin
        if (mem_rsp_valid) begin
          w_state_next = S_FILL;
        end
      end
      S_FILL: begin
        fill_we      = 1'b1;
        w_state_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid    = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_tag      <= '0;
      r_idx      <= '0;
      r_victim   <= '0;
      r_replaced <= 1'b0;
      r_rsp_hit  <= 1'b0;
      r_rsp_way  <= '0;
      r_line     <= '0;
    end else begin
      if ((r_state == S_IDLE) && req_valid) begin
        r_tag <= req_tag;
        r_idx <= req_idx;
      end
      if (w_hit_evt) begin
        r_rsp_hit <= 1'b1;
        r_rsp_way <= hit_encode;
      end
      // A full set falls back to the per-set round-robin pointer.
      if (w_miss_evt) begin
        r_rsp_hit  <= 1'b0;
        r_victim   <= w_free_found ? w_free_way : w_rr_cur;
        r_replaced <= !w_free_found;
      end
      if ((r_state == S_MWAIT) && mem_rsp_valid) begin
        r_line <= mem_rsp_data;
      end
      if (r_state == S_FILL) begin
        r_rsp_hit <= 1'b0;
        r_rsp_way <= r_victim;
      end
    end
  end

  // Pointer advances only when a valid line was actually evicted; DOSA is a
  // power of two so the natural wrap of the field is modulo DOSA.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < SETS; i++) begin
        r_rr_ptr[i] <= '0;
      end
    end else if ((r_state == S_FILL) && r_replaced) begin
      r_rr_ptr[r_idx] <= r_rr_ptr[r_idx] + ENCODER_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit_evt && (r_hit_cnt != 32'hFFFF_FFFF)) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if (w_miss_evt && (r_miss_cnt != 32'hFFFF_FFFF)) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign tag_rd_idx   = busy ? r_idx : '0;
  assign mem_req_addr = mem_req_valid ? {r_tag, r_idx} : '0;
  assign fill_way     = fill_we ? r_victim : '0;
  assign fill_idx     = fill_we ? r_idx : '0;
  assign fill_tag     = fill_we ? {1'b1, r_tag} : '0;
  assign fill_data    = fill_we ? r_line : '0;
  assign rsp_hit      = r_rsp_hit;
  assign rsp_way      = r_rsp_way;
  assign hit_cnt      = r_hit_cnt;
  assign miss_cnt     = r_miss_cnt;

endmodule

// File: tb/tb_cache_lookup_ctrl.sv
// Randomised bench for cache_lookup_ctrl: a transaction-level model predicts the
// cycle of every strobe from the acceptance cycle and checks outputs each cycle.
module tb_cache_lookup_ctrl;

  localparam int DOSA   = 4;
  localparam int EW     = 2;
  localparam int TAG_W  = 16;
  localparam int IDX_W  = 6;
  localparam int DATA_W = 512;

  logic              clk = 1'b0;
  logic              RST_N = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [TAG_W-1:0]  req_tag = '0;
  logic [IDX_W-1:0]  req_idx = '0;
  logic [IDX_W-1:0]  tag_rd_idx;
  logic              peEN_2;
  logic              HIT = 1'b0;
  logic [EW-1:0]     hit_encode = '0;
  logic [DOSA-1:0]   way_valid = '0;
  logic              mem_req_valid;
  logic              mem_req_ready = 1'b0;
  logic [TAG_W+IDX_W-1:0] mem_req_addr;
  logic              mem_rsp_valid = 1'b0;
  logic [DATA_W-1:0] mem_rsp_data = '0;
  logic              fill_we;
  logic [EW-1:0]     fill_way;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W:0]    fill_tag;
  logic [DATA_W-1:0] fill_data;
  logic              rsp_valid;
  logic              rsp_hit;
  logic [EW-1:0]     rsp_way;
  logic              busy;
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;

  always #5 clk = ~clk;

  cache_lookup_ctrl #(
    .DOSA(DOSA), .ENCODER_WIDTH(EW), .TAG_W(TAG_W), .IDX_W(IDX_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag), .req_idx(req_idx),
    .tag_rd_idx(tag_rd_idx), .peEN_2(peEN_2),
    .HIT(HIT), .hit_encode(hit_encode), .way_valid(way_valid),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .fill_we(fill_we), .fill_way(fill_way), .fill_idx(fill_idx), .fill_tag(fill_tag),
    .fill_data(fill_data),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way), .busy(busy),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // off: -2 = in/just after reset, -1 = idle gap, k >= 0 = k cycles after acceptance cycle
  int                off = -2;
  bit                c_hit;
  int                c_dr, c_ds, c_total;
  logic [TAG_W-1:0]  c_tag;
  logic [IDX_W-1:0]  c_idx;
  logic [EW-1:0]     c_way;
  logic [DATA_W-1:0] c_data;
  logic [31:0]       c_hc_before, c_hc_after, c_mc_before, c_mc_after;
  bit                pin_en;
  logic [EW-1:0]     pin_way;
  logic [31:0]       pin_hc, pin_mc;

  int                m_rr [64];
  logic [31:0]       m_hc = '0;
  logic [31:0]       m_mc = '0;

  task automatic cmp(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit e_idle, e_peen, e_mreq, e_fill, e_rsp;
    if (chk_en) begin
      e_idle = (off < 1);
      e_peen = (off == 1);
      e_mreq = (off >= 3) && !c_hit && (off <= 3 + c_dr);
      e_fill = (off >= 1) && !c_hit && (off == 5 + c_dr + c_ds);
      e_rsp  = (off >= 1) && (off == c_total);
      cmp("req_ready", 512'(req_ready), 512'(e_idle));
      cmp("busy", 512'(busy), 512'(!e_idle));
      cmp("peEN_2", 512'(peEN_2), 512'(e_peen));
      cmp("mem_req_valid", 512'(mem_req_valid), 512'(e_mreq));
      cmp("fill_we", 512'(fill_we), 512'(e_fill));
      cmp("rsp_valid", 512'(rsp_valid), 512'(e_rsp));
      if (off == -2) begin
        cmp("rst_rsp_hit", 512'(rsp_hit), 512'(0));
        cmp("rst_rsp_way", 512'(rsp_way), 512'(0));
        cmp("rst_hit_cnt", 512'(hit_cnt), 512'(0));
        cmp("rst_miss_cnt", 512'(miss_cnt), 512'(0));
        cmp("rst_mem_req_addr", 512'(mem_req_addr), 512'(0));
        cmp("rst_tag_rd_idx", 512'(tag_rd_idx), 512'(0));
        cmp("rst_fill_tag", 512'(fill_tag), 512'(0));
        cmp("rst_fill_data", fill_data, 512'(0));
      end else if (off == -1) begin
        cmp("idle_hit_cnt", 512'(hit_cnt), 512'(m_hc));
        cmp("idle_miss_cnt", 512'(miss_cnt), 512'(m_mc));
      end else begin
        cmp("hit_cnt", 512'(hit_cnt), 512'((off >= 3) ? c_hc_after : c_hc_before));
        cmp("miss_cnt", 512'(miss_cnt), 512'((off >= 3) ? c_mc_after : c_mc_before));
        if (off >= 1) cmp("tag_rd_idx", 512'(tag_rd_idx), 512'(c_idx));
        if (e_mreq) cmp("mem_req_addr", 512'(mem_req_addr), 512'({c_tag, c_idx}));
        if (e_fill) begin
          cmp("fill_way", 512'(fill_way), 512'(c_way));
          cmp("fill_idx", 512'(fill_idx), 512'(c_idx));
          cmp("fill_tag", 512'(fill_tag), 512'({1'b1, c_tag}));
          cmp("fill_data", fill_data, c_data);
        end
        if (e_rsp) begin
          cmp("rsp_hit", 512'(rsp_hit), 512'(c_hit));
          cmp("rsp_way", 512'(rsp_way), 512'(c_way));
          if (pin_en) begin
            cmp("pin_way", 512'(rsp_way), 512'(pin_way));
            cmp("pin_hit_cnt", 512'(hit_cnt), 512'(pin_hc));
            cmp("pin_miss_cnt", 512'(miss_cnt), 512'(pin_mc));
          end
        end
      end
    end
  end

  task automatic rand_data();
    for (int j = 0; j < DATA_W / 32; j++) mem_rsp_data[j*32 +: 32] = $urandom;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    off = -2;
    m_hc = '0;
    m_mc = '0;
    for (int s = 0; s < 64; s++) m_rr[s] = 0;
    req_valid = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    RST_N = 1'b1;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b1;
    rand_data();
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      mem_rsp_valid = 1'($urandom);
      rand_data();
    end
  endtask

  task automatic run_txn(input bit hit, input logic [EW-1:0] hway, input logic [DOSA-1:0] wv,
                         input int dr, input int ds, input logic [TAG_W-1:0] tag,
                         input logic [IDX_W-1:0] idx, input int abort_k,
                         input bit pe, input logic [EW-1:0] pway,
                         input logic [31:0] phc, input logic [31:0] pmc);
    bit found;
    logic [EW-1:0] victim;
    c_hc_before = m_hc;
    c_mc_before = m_mc;
    if (hit) begin
      c_way = hway;
      if (m_hc != 32'hFFFF_FFFF) m_hc++;
    end else begin
      found = 1'b0;
      victim = '0;
      for (int w = 0; w < DOSA; w++) begin
        if (!found && !wv[w]) begin
          found = 1'b1;
          victim = EW'(w);
        end
      end
      if (!found) begin
        victim = EW'(m_rr[idx]);
        m_rr[idx] = (m_rr[idx] + 1) % DOSA;
      end
      c_way = victim;
      if (m_mc != 32'hFFFF_FFFF) m_mc++;
    end
    c_hc_after = m_hc;
    c_mc_after = m_mc;
    c_hit = hit; c_dr = dr; c_ds = ds; c_tag = tag; c_idx = idx;
    c_total = hit ? 3 : 6 + dr + ds;
    pin_en = pe; pin_way = pway; pin_hc = phc; pin_mc = pmc;
    req_valid = 1'b1; req_tag = tag; req_idx = idx;
    off = 0;
    for (int k = 1; k <= c_total; k++) begin
      @(posedge clk); #1;
      if (abort_k != 0 && k == abort_k) begin
        do_reset();
        return;
      end
      off = k;
      req_valid = 1'($urandom);
      req_tag = TAG_W'($urandom);
      req_idx = IDX_W'($urandom);
      if (k == 2) begin
        HIT = hit;
        hit_encode = hit ? hway : EW'($urandom);
        way_valid = wv;
      end else begin
        HIT = 1'($urandom);
        hit_encode = EW'($urandom);
        way_valid = DOSA'($urandom);
      end
      if (!hit && k >= 3 && k < 3 + dr) mem_req_ready = 1'b0;
      else if (!hit && k == 3 + dr) mem_req_ready = 1'b1;
      else mem_req_ready = 1'($urandom);
      rand_data();
      if (!hit && k >= 4 + dr && k < 4 + dr + ds) mem_rsp_valid = 1'b0;
      else if (!hit && k == 4 + dr + ds) begin
        mem_rsp_valid = 1'b1;
        c_data = mem_rsp_data;
      end else mem_rsp_valid = 1'($urandom);
    end
    @(posedge clk); #1;
    off = -1;
    req_valid = 1'b0;
  endtask

  initial begin
    for (int s = 0; s < 64; s++) m_rr[s] = 0;
    chk_en = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    RST_N = 1'b1;
    idle(2);
    // hit on way 2
    run_txn(1, 2, 4'hF, 0, 0, 16'h1234, 6'd5, 0, 1, 2, 32'd1, 32'd0);
    // cold misses to set 3
    run_txn(0, 0, 4'b0000, 0, 0, 16'hA001, 6'd3, 0, 1, 0, 32'd1, 32'd1);
    run_txn(0, 0, 4'b0001, 0, 0, 16'hA002, 6'd3, 0, 1, 1, 32'd1, 32'd2);
    // round-robin replacement in a full set 7
    for (int i = 0; i < 5; i++)
      run_txn(0, 0, 4'hF, 0, 0, 16'hB000 + 16'(i), 6'd7, 0, 1, EW'(i % 4), 32'd1, 32'(3 + i));
    run_txn(0, 0, 4'hF, 0, 0, 16'hC008, 6'd8, 0, 1, 0, 32'd1, 32'd8);
    run_txn(0, 0, 4'hF, 0, 0, 16'hA003, 6'd3, 0, 1, 0, 32'd1, 32'd9);
    // fetch back-pressure and slow response: rsp_valid lands 14 cycles after acceptance
    run_txn(0, 0, 4'b0111, 5, 3, 16'hD00D, 6'd9, 0, 1, 3, 32'd1, 32'd10);
    for (int i = 0; i < 40; i++) begin
      run_txn(($urandom % 3) == 0, EW'($urandom), ($urandom % 2) ? 4'hF : DOSA'($urandom),
              int'($urandom % 4), int'($urandom % 4), TAG_W'($urandom), IDX_W'($urandom % 4),
              0, 0, 0, 32'd0, 32'd0);
      idle(int'($urandom % 3));
    end
    // reset while waiting for the memory response
    run_txn(0, 0, 4'hF, 0, 10, 16'hE000, 6'd2, 6, 0, 0, 32'd0, 32'd0);
    idle(1);
    run_txn(1, 1, 4'hF, 0, 0, 16'hE001, 6'd2, 0, 1, 1, 32'd1, 32'd0);
    run_txn(0, 0, 4'hF, 1, 1, 16'hE002, 6'd7, 0, 1, 0, 32'd1, 32'd1);
    // counter saturation
    dut.r_hit_cnt <= 32'hFFFF_FFFE;
    m_hc = 32'hFFFF_FFFE;
    run_txn(1, 3, 4'hF, 0, 0, 16'hF001, 6'd1, 0, 1, 3, 32'hFFFF_FFFF, 32'd1);
    run_txn(1, 0, 4'hF, 0, 0, 16'hF002, 6'd1, 0, 1, 0, 32'hFFFF_FFFF, 32'd1);
    idle(2);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
